// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/memory controller slice.
// Keeps the FSM encoding and the hard-wired zero register in one place.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// MW->E bypass comparator for one source operand.
// Writes to x0 are never forwarded because x0 always reads as zero.
module forward_unit
    import hazard_pkg::*;
(
    input  logic       regWriteMW,
    input  logic [4:0] writeAddressMW,
    input  logic [4:0] rsE,
    output logic       forwardE
);

    assign forwardE = regWriteMW && (writeAddressMW != REG_ZERO) && (writeAddressMW == rsE);

endmodule

// File: rtl/hazard_mem_controller.sv
// Stall/flush/forwarding controller for the 3-stage core: sequences the MW
// data-memory handshake, bounds it with a timeout and counts stall cycles.
module hazard_mem_controller
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             memReadMW,
    input  logic             memWriteMW,
    input  logic             dmemAck,
    input  logic             regWriteMW,
    input  logic [4:0]       writeAddressMW,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic             branchTakenE,
    input  logic             perfClear,
    output logic             dmemReq,
    output logic             stallF,
    output logic             stallMW,
    output logic             flushFE,
    output logic             forwardAE,
    output logic             forwardBE,
    output logic             busError,
    output logic             irqAllowed,
    output logic [CNT_W-1:0] stallCount
);

    localparam int                WCNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

    ctrl_state_t       state_q, state_d;
    logic [WCNT_W-1:0] waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]  stallCount_q, stallCount_d;

    logic access;
    logic reqRaw, stallRaw, errRaw;
    logic fwdA, fwdB;

    assign access = memReadMW | memWriteMW;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            waitCnt_q    <= '0;
            stallCount_q <= '0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            stallCount_q <= stallCount_d;
        end
    end

    // An ack in the final WAIT cycle is checked first, so it beats the timeout.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        reqRaw    = 1'b0;
        stallRaw  = 1'b0;
        errRaw    = 1'b0;
        unique case (state_q)
            IDLE: begin
                reqRaw = access;
                if (access && !dmemAck) begin
                    stallRaw  = 1'b1;
                    state_d   = WAIT;
                    waitCnt_d = '0;
                end
            end
            WAIT: begin
                reqRaw   = 1'b1;
                stallRaw = 1'b1;
                if (dmemAck) begin
                    state_d = IDLE;
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    waitCnt_d = waitCnt_q + WCNT_W'(1);
                end
            end
            ERR: begin
                errRaw  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stallCount_d = stallCount_q;
        if (perfClear) begin
            stallCount_d = '0;
        end else if (stallF && !(&stallCount_q)) begin
            stallCount_d = stallCount_q + CNT_W'(1);
        end
    end

    forward_unit uFwdA (
        .regWriteMW     (regWriteMW),
        .writeAddressMW (writeAddressMW),
        .rsE            (rs1E),
        .forwardE       (fwdA)
    );

    forward_unit uFwdB (
        .regWriteMW     (regWriteMW),
        .writeAddressMW (writeAddressMW),
        .rsE            (rs2E),
        .forwardE       (fwdB)
    );

    // Reset masks every output so an in-flight access is dropped without an error.
    assign dmemReq    = !reset && reqRaw;
    assign stallF     = !reset && stallRaw;
    assign stallMW    = !reset && stallRaw;
    assign busError   = !reset && errRaw;
    assign flushFE    = reset || (branchTakenE && !stallF) || errRaw;
    assign irqAllowed = !reset && (state_q == IDLE) && !(access && !dmemAck);
    assign forwardAE  = !reset && fwdA;
    assign forwardBE  = !reset && fwdB;
    assign stallCount = stallCount_q;

endmodule

// File: tb/tb_hazard_mem_controller.sv
// Directed self-checking bench for hazard_mem_controller (MAX_WAIT=16, CNT_W=4
// so stall-counter saturation is reachable in a few dozen cycles).
module tb_hazard_mem_controller;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             memReadMW, memWriteMW, dmemAck, regWriteMW;
    logic [4:0]       writeAddressMW, rs1E, rs2E;
    logic             branchTakenE, perfClear;
    logic             dmemReq, stallF, stallMW, flushFE;
    logic             forwardAE, forwardBE, busError, irqAllowed;
    logic [CNT_W-1:0] stallCount;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clock = ~clock;

    hazard_mem_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .memReadMW      (memReadMW),
        .memWriteMW     (memWriteMW),
        .dmemAck        (dmemAck),
        .regWriteMW     (regWriteMW),
        .writeAddressMW (writeAddressMW),
        .rs1E           (rs1E),
        .rs2E           (rs2E),
        .branchTakenE   (branchTakenE),
        .perfClear      (perfClear),
        .dmemReq        (dmemReq),
        .stallF         (stallF),
        .stallMW        (stallMW),
        .flushFE        (flushFE),
        .forwardAE      (forwardAE),
        .forwardBE      (forwardBE),
        .busError       (busError),
        .irqAllowed     (irqAllowed),
        .stallCount     (stallCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic ack);
        memReadMW  = rd;
        memWriteMW = wr;
        dmemAck    = ack;
        #1;
    endtask

    initial begin
        reset = 1'b1; memReadMW = 1'b1; memWriteMW = 1'b0; dmemAck = 1'b0;
        regWriteMW = 1'b1; writeAddressMW = 5'd5; rs1E = 5'd5; rs2E = 5'd5;
        branchTakenE = 1'b0; perfClear = 1'b0;
        #2;
        checkOutput("rst_dmemReq", 32'(dmemReq), 32'd0);
        checkOutput("rst_stallF", 32'(stallF), 32'd0);
        checkOutput("rst_flushFE", 32'(flushFE), 32'd1);
        checkOutput("rst_forwardAE", 32'(forwardAE), 32'd0);
        checkOutput("rst_irqAllowed", 32'(irqAllowed), 32'd0);
        tick();
        reset = 1'b0; regWriteMW = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_stallCount", 32'(stallCount), 32'd0);
        checkOutput("idle_irqAllowed", 32'(irqAllowed), 32'd1);
        checkOutput("idle_flushFE", 32'(flushFE), 32'd0);

        // Zero-wait load
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("zw_dmemReq", 32'(dmemReq), 32'd1);
        checkOutput("zw_stallF", 32'(stallF), 32'd0);
        checkOutput("zw_irqAllowed", 32'(irqAllowed), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("zw_dmemReq_after", 32'(dmemReq), 32'd0);
        checkOutput("zw_stallCount", 32'(stallCount), 32'd0);

        // Store acked after three WAIT cycles: four stalled cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 3));
            checkOutput($sformatf("st_stallF_%0d", i), 32'(stallF), 32'd1);
            checkOutput($sformatf("st_stallMW_%0d", i), 32'(stallMW), 32'd1);
            checkOutput($sformatf("st_dmemReq_%0d", i), 32'(dmemReq), 32'd1);
            checkOutput($sformatf("st_irq_%0d", i), 32'(irqAllowed), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("st_stallF_done", 32'(stallF), 32'd0);
        checkOutput("st_stallCount", 32'(stallCount), 32'd4);
        checkOutput("st_irq_done", 32'(irqAllowed), 32'd1);

        // Load never acked: one IDLE stall + 16 WAIT cycles, then ERR
        for (int i = 0; i < 1 + MAX_WAIT; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("to_stallF_%0d", i), 32'(stallF), 32'd1);
            checkOutput($sformatf("to_busError_%0d", i), 32'(busError), 32'd0);
            tick();
        end
        checkOutput("err_busError", 32'(busError), 32'd1);
        checkOutput("err_flushFE", 32'(flushFE), 32'd1);
        checkOutput("err_dmemReq", 32'(dmemReq), 32'd0);
        checkOutput("err_stallF", 32'(stallF), 32'd0);
        checkOutput("err_irq", 32'(irqAllowed), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_err_busError", 32'(busError), 32'd0);
        checkOutput("post_err_irq", 32'(irqAllowed), 32'd1);
        checkOutput("post_err_flushFE", 32'(flushFE), 32'd0);
        checkOutput("sat_stallCount", 32'(stallCount), 32'd15);

        // Ack arrives in the 16th WAIT cycle: ack wins, no error
        for (int i = 0; i < 1 + MAX_WAIT; i++) begin
            applyStimulus(1'b1, 1'b0, (i == MAX_WAIT));
            checkOutput($sformatf("late_stallF_%0d", i), 32'(stallF), 32'd1);
            checkOutput($sformatf("late_busError_%0d", i), 32'(busError), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("late_busError_after", 32'(busError), 32'd0);
        checkOutput("late_stallF_after", 32'(stallF), 32'd0);
        checkOutput("late_irq_after", 32'(irqAllowed), 32'd1);
        checkOutput("sat_hold_stallCount", 32'(stallCount), 32'd15);

        // perfClear beats a simultaneous stall, then a branch is deferred across a 2-cycle stall
        perfClear = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("clr_stallF", 32'(stallF), 32'd1);
        tick();
        perfClear = 1'b0; branchTakenE = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("clr_stallCount", 32'(stallCount), 32'd0);
        checkOutput("br_flush_w1", 32'(flushFE), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("br_stall_w2", 32'(stallF), 32'd1);
        checkOutput("br_flush_w2", 32'(flushFE), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("br_stall_rel", 32'(stallF), 32'd0);
        checkOutput("br_flush_rel", 32'(flushFE), 32'd1);
        checkOutput("br_stallCount", 32'(stallCount), 32'd2);
        branchTakenE = 1'b0;

        // Forwarding
        regWriteMW = 1'b1; writeAddressMW = 5'd5; rs1E = 5'd5; rs2E = 5'd5; #1;
        checkOutput("fwd_A_5", 32'(forwardAE), 32'd1);
        checkOutput("fwd_B_5", 32'(forwardBE), 32'd1);
        writeAddressMW = 5'd0; rs1E = 5'd0; rs2E = 5'd0; #1;
        checkOutput("fwd_A_x0", 32'(forwardAE), 32'd0);
        checkOutput("fwd_B_x0", 32'(forwardBE), 32'd0);
        writeAddressMW = 5'd5; rs1E = 5'd5; rs2E = 5'd6; #1;
        checkOutput("fwd_A_match", 32'(forwardAE), 32'd1);
        checkOutput("fwd_B_miss", 32'(forwardBE), 32'd0);
        regWriteMW = 1'b0; #1;
        checkOutput("fwd_A_nowrite", 32'(forwardAE), 32'd0);

        // Reset in the middle of WAIT abandons the access silently
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rw_dmemReq_wait", 32'(dmemReq), 32'd1);
        reset = 1'b1; #1;
        checkOutput("rw_dmemReq_rst", 32'(dmemReq), 32'd0);
        checkOutput("rw_busError_rst", 32'(busError), 32'd0);
        checkOutput("rw_stallF_rst", 32'(stallF), 32'd0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rw_irq_idle", 32'(irqAllowed), 32'd1);
        checkOutput("rw_busError_after", 32'(busError), 32'd0);
        checkOutput("rw_stallCount", 32'(stallCount), 32'd0);
        tick();
        checkOutput("rw_busError_after2", 32'(busError), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_mem_controller.md
Name: hazard_mem_controller

Overview:
Central stall/flush/forwarding controller for the 3-stage core (Fetch, Decode/Execute, Memory/Writeback).
- Sequences the data-memory request/acknowledge handshake of the instruction in MW.
- Drives stallF and stallMW into both pipeline registers.
- Squashes the F→E register on taken branches and on bus-timeout errors.
- Selects MW→E operand forwarding and keeps a saturating stall-cycle performance counter.

Parameters:
MAX_WAIT, 16, max cycles spent in WAIT before a bus error is raised (≥2)
CNT_W, 32, width of stall performance counter

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
memReadMW  in  1  MW instruction is a load
memWriteMW  in  1  MW instruction is a store
dmemAck  in  1  data memory completes the access this cycle
regWriteMW  in  1  MW instruction writes the register file
writeAddressMW  in  5  destination register of MW instruction
rs1E  in  5  source register A of E instruction
rs2E  in  5  source register B of E instruction
branchTakenE  in  1  E instruction redirects the PC
perfClear  in  1  clear stall counter
dmemReq  out  1  data memory request
stallF  out  1  hold PC and F→E register
stallMW  out  1  hold E→MW register
flushFE  out  1  load bubble into F→E register
forwardAE  out  1  1 = operand A taken from MW writeback data
forwardBE  out  1  1 = operand B taken from MW writeback data
busError  out  1  one-cycle pulse: access timed out
irqAllowed  out  1  interrupts/traps may be taken this cycle
stallCount  out  CNT_W  cycles with stallF=1, saturating

Behaviour:
- access = memReadMW | memWriteMW.
- FSM states: IDLE, WAIT, ERR. Registered state plus waitCnt, width $clog2(MAX_WAIT+1). All outputs decode combinationally from state and inputs.

IDLE:
- dmemReq = access.
- access & dmemAck: zero-wait, no stall, stay IDLE.
- access & !dmemAck: stallF = stallMW = 1; next state WAIT; waitCnt ← 0.

WAIT:
- dmemReq = 1 and stallF = stallMW = 1 every cycle.
- dmemAck: stall still 1 this cycle; next state IDLE. The pipeline advances on the following edge.
- !dmemAck and waitCnt == MAX_WAIT-1: next state ERR. Otherwise waitCnt++.
- WAIT therefore lasts at most MAX_WAIT cycles. An ack in the final WAIT cycle wins over the timeout.

ERR (exactly 1 cycle):
- busError = 1, dmemReq = 0, stall = 0, flushFE = 1; next state IDLE.
- The MW instruction is abandoned. The trap unit consumes busError.

Flush and interrupt rules:
- flushFE = (branchTakenE & !stallF) | (state == ERR).
- A branch resolved while stalled is held in E, so its flush is deferred until the stall releases.
- irqAllowed = (state == IDLE) & !(access & !dmemAck). Traps never split a memory access.

Forwarding:
- forwardAE = regWriteMW & (writeAddressMW != 0) & (writeAddressMW == rs1E). forwardBE uses rs2E.
- Forwarding stays active while stalled. Load data is valid in the ack cycle because E is held until then.

stallCount:
- Increments on every cycle with stallF = 1.
- Saturates at all-ones, never wraps.
- perfClear has priority over increment: cleared to 0 that cycle.

Reset:
- Registers: state = IDLE, waitCnt = 0, stallCount = 0.
- While reset is high: dmemReq = stallF = stallMW = busError = irqAllowed = 0, flushFE = 1, forwardAE = forwardBE = 0.
- Reset during WAIT abandons the access: dmemReq drops on the reset cycle and no busError is raised.

Decomposition:
- Shared package hazard_pkg: typedef enum ctrl_state_t {IDLE, WAIT, ERR}; constant REG_ZERO = 5'd0.
- One natural sub-module, forward_unit: the purely combinational rs/rd comparators, instantiated once per operand.
- FSM, timeout counter and perf counter stay in the top module.

Test Plan:
- Load with dmemAck in the same cycle → dmemReq 1 for 1 cycle, stallF = 0, stallCount stays 0.
- Store, ack after 3 cycles → stallF/stallMW high for 4 cycles (IDLE + 3 WAIT), stallCount = 4, irqAllowed low throughout.
- Load, no ack, MAX_WAIT = 16 → 16 WAIT cycles, then busError and flushFE high for exactly 1 cycle, dmemReq 0 in ERR, irqAllowed back to 1 next cycle. Repeat with ack in the 16th WAIT cycle → no busError.
- branchTakenE = 1 during a 2-cycle stall → flushFE stays 0 until stallF falls, then 1.
- regWriteMW = 1, writeAddressMW = 5, rs1E = 5, rs2E = 5 → forwardAE = forwardBE = 1. Same with writeAddressMW = 0 → both 0.
- Preload stallCount = all-ones (CNT_W = 4, 15 stalled cycles), stall again → stays 15. perfClear with a simultaneous stall → 0. Reset asserted mid-WAIT → dmemReq 0, state IDLE, no busError.
